// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared 640x480@60 timing constants and helpers for the VGA
//             timing generator, sprite and ROM-address stages.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int CNT_W = 10;  // DrawX / DrawY width
  localparam int FC_W  = 8;   // frame counter width

  // Horizontal timing in pixels
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Vertical timing in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Derived sync windows (inclusive bounds)
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // True when a counter value lies inside an inclusive window
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : 640x480@60 VGA raster counters with registered, zero-skew
//             sync / blank / frame-start outputs and a frame counter.
//             Timing overrides default to the vga_pkg constants.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE_PX = H_ACTIVE,
  parameter int H_FP_PX     = H_SYNC_START - H_ACTIVE,
  parameter int H_SYNC_PX   = H_SYNC_END - H_SYNC_START + 1,
  parameter int H_BP_PX     = H_TOTAL - H_SYNC_END - 1,
  parameter int V_ACTIVE_LN = V_ACTIVE,
  parameter int V_FP_LN     = V_SYNC_START - V_ACTIVE,
  parameter int V_SYNC_LN   = V_SYNC_END - V_SYNC_START + 1,
  parameter int V_BP_LN     = V_TOTAL - V_SYNC_END - 1
)(
  input  logic             vga_clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             hs,
  output logic             vs,
  output logic             blank,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  localparam logic [CNT_W-1:0] C_H_ACT  = CNT_W'(H_ACTIVE_PX);
  localparam logic [CNT_W-1:0] C_H_SS   = CNT_W'(H_ACTIVE_PX + H_FP_PX);
  localparam logic [CNT_W-1:0] C_H_SE   = CNT_W'(H_ACTIVE_PX + H_FP_PX + H_SYNC_PX - 1);
  localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_ACTIVE_PX + H_FP_PX + H_SYNC_PX + H_BP_PX - 1);
  localparam logic [CNT_W-1:0] C_V_ACT  = CNT_W'(V_ACTIVE_LN);
  localparam logic [CNT_W-1:0] C_V_SS   = CNT_W'(V_ACTIVE_LN + V_FP_LN);
  localparam logic [CNT_W-1:0] C_V_SE   = CNT_W'(V_ACTIVE_LN + V_FP_LN + V_SYNC_LN - 1);
  localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_ACTIVE_LN + V_FP_LN + V_SYNC_LN + V_BP_LN - 1);

  logic [CNT_W-1:0] r_x, r_y;
  logic             r_hs, r_vs, r_blank, r_fs;
  logic [FC_W-1:0]  r_fc;

  logic [CNT_W-1:0] w_x_nxt, w_y_nxt;
  logic             w_x_last, w_y_last, w_wrap;
  logic             w_hs_nxt, w_vs_nxt, w_blank_nxt;
  logic [FC_W-1:0]  w_fc_nxt;

  // Next raster position with explicit wraps; outputs decode the next
  // position so they land in the same register stage as the counters.
  always_comb begin
    w_x_last    = (r_x == C_H_LAST);
    w_y_last    = (r_y == C_V_LAST);
    w_wrap      = w_x_last && w_y_last;
    w_x_nxt     = w_x_last ? '0 : r_x + 10'd1;
    w_y_nxt     = r_y;
    if (w_x_last) begin
      w_y_nxt   = w_y_last ? '0 : r_y + 10'd1;
    end
    w_hs_nxt    = !in_window(w_x_nxt, C_H_SS, C_H_SE);
    w_vs_nxt    = !in_window(w_y_nxt, C_V_SS, C_V_SE);
    w_blank_nxt = (w_x_nxt < C_H_ACT) && (w_y_nxt < C_V_ACT);
    w_fc_nxt    = w_wrap ? r_fc + 8'd1 : r_fc;
  end

  // Counter and output register stage; reset parks the raster at a dark (0,0)
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_blank <= 1'b0;
      r_fs    <= 1'b0;
      r_fc    <= '0;
    end else begin
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_hs    <= w_hs_nxt;
      r_vs    <= w_vs_nxt;
      r_blank <= w_blank_nxt;
      r_fs    <= w_wrap;
      r_fc    <= w_fc_nxt;
    end
  end

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign frame_start = r_fs;
  assign frame_count = r_fc;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. A full-timing instance
//             covers line timing and mid-line reset; a reduced-timing instance
//             covers frame wrap, vsync, and the 256-frame counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct {
    int         x;
    int         y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn_f = 1'b0;
  logic rstn_s = 1'b0;
  logic sel = 1'b0;  // 0: full-timing DUT, 1: reduced-timing DUT

  logic [9:0] fx, fy, sx, sy;
  logic       fhs, fvs, fbl, ffs, shs, svs, sbl, sfs;
  logic [7:0] ffc, sfc;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int ha, hss, hse, htot, va, vss, vse, vtot;
  int mx, my;
  logic mfs, mdark;
  logic [7:0] mfc;
  exp_t sbq[$];

  // Per-run observation counters
  int hs_low_cnt, vs_low_cnt, fs_cnt;

  always #20 clk = ~clk;

  vga_timing_gen u_full (
    .vga_clk(clk), .reset_n(rstn_f), .DrawX(fx), .DrawY(fy), .hs(fhs), .vs(fvs),
    .blank(fbl), .frame_start(ffs), .frame_count(ffc)
  );

  vga_timing_gen #(
    .H_ACTIVE_PX(8), .H_FP_PX(2), .H_SYNC_PX(3), .H_BP_PX(3),
    .V_ACTIVE_LN(6), .V_FP_LN(1), .V_SYNC_LN(2), .V_BP_LN(2)
  ) u_small (
    .vga_clk(clk), .reset_n(rstn_s), .DrawX(sx), .DrawY(sy), .hs(shs), .vs(svs),
    .blank(sbl), .frame_start(sfs), .frame_count(sfc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (x=%0d y=%0d)", tag, obs, exp, mx, my);
    end
  endtask

  task automatic set_full();
    ha = 640; hss = 656; hse = 751; htot = 800;
    va = 480; vss = 490; vse = 491; vtot = 525;
  endtask

  task automatic set_small();
    ha = 8; hss = 10; hse = 12; htot = 16;
    va = 6; vss = 7;  vse = 8;  vtot = 11;
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mfs = 1'b0; mfc = 8'd0; mdark = 1'b1;
  endtask

  task automatic model_advance();
    mfs = 1'b0;
    mdark = 1'b0;
    if (mx == htot - 1) begin
      mx = 0;
      if (my == vtot - 1) begin
        my = 0;
        mfs = 1'b1;
        mfc = mfc + 8'd1;
      end else begin
        my = my + 1;
      end
    end else begin
      mx = mx + 1;
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.x     = mx;
    e.y     = my;
    e.hs    = !(mx >= hss && mx <= hse);
    e.vs    = !(my >= vss && my <= vse);
    e.blank = !mdark && (mx < ha) && (my < va);
    e.fs    = mfs;
    e.fc    = mfc;
    return e;
  endfunction

  // Pop one expectation and compare it with the selected DUT's outputs
  task automatic compare_pop(input string tag);
    exp_t e;
    logic [9:0] ox, oy;
    logic ohs, ovs, obl, ofs;
    logic [7:0] ofc;
    e = sbq.pop_front();
    ox  = sel ? sx  : fx;   oy  = sel ? sy  : fy;
    ohs = sel ? shs : fhs;  ovs = sel ? svs : fvs;
    obl = sel ? sbl : fbl;  ofs = sel ? sfs : ffs;
    ofc = sel ? sfc : ffc;
    chk({tag, ".x"},     32'(ox),  32'(e.x));
    chk({tag, ".y"},     32'(oy),  32'(e.y));
    chk({tag, ".hs"},    32'(ohs), 32'(e.hs));
    chk({tag, ".vs"},    32'(ovs), 32'(e.vs));
    chk({tag, ".blank"}, 32'(obl), 32'(e.blank));
    chk({tag, ".fs"},    32'(ofs), 32'(e.fs));
    chk({tag, ".fc"},    32'(ofc), 32'(e.fc));
    if (ohs === 1'b0) hs_low_cnt++;
    if (ovs === 1'b0) vs_low_cnt++;
    if (ofs === 1'b1) fs_cnt++;
  endtask

  // One clock: predict the post-edge state, then compare after the edge
  task automatic cycle(input string tag);
    logic rn;
    rn = sel ? rstn_s : rstn_f;
    if (!rn) model_reset();
    else     model_advance();
    sbq.push_back(model_expect());
    @(posedge clk);
    #1;
    compare_pop(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic clear_counts();
    hs_low_cnt = 0; vs_low_cnt = 0; fs_cnt = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    if (sel) rstn_s = 1'b1;
    else     rstn_f = 1'b1;
  endtask

  // Assert reset between edges and check the clear without any clock
  task automatic async_reset(input string tag);
    if (sel) rstn_s = 1'b0;
    else     rstn_f = 1'b0;
    model_reset();
    sbq.push_back(model_expect());
    #2;
    compare_pop(tag);
  endtask

  initial begin
    // ---------------- full-timing instance ----------------
    sel = 1'b0;
    set_full();
    model_reset();
    clear_counts();
    run("reset_full", 3);

    release_reset();
    cycle("first_cycle");
    chk("first_x_is_1", 32'(fx), 32'd1);
    chk("first_blank_on", 32'(fbl), 32'd1);
    chk("first_no_fs", 32'(ffs), 32'd0);

    clear_counts();
    run("line0", 799);  // ends on (0,1)
    chk("line0_hs_low_cycles", 32'(hs_low_cnt), 32'd96);
    chk("line_wrap_x", 32'(fx), 32'd0);
    chk("line_wrap_y", 32'(fy), 32'd1);

    run("line1", 700);  // ends on (700,1), inside hsync
    chk("pre_reset_hs_low", 32'(fhs), 32'd0);
    async_reset("midline_reset");
    run("reset_hold_full", 2);

    release_reset();
    clear_counts();
    run("relaunch_line", 800);
    chk("relaunch_hs_low_cycles", 32'(hs_low_cnt), 32'd96);
    chk("relaunch_wrap_y", 32'(fy), 32'd1);

    // ---------------- reduced-timing instance ----------------
    @(negedge clk);
    rstn_f = 1'b0;
    sel = 1'b1;
    set_small();
    model_reset();
    run("reset_small", 2);

    release_reset();
    clear_counts();
    run("two_frames", 2 * 176);
    chk("vs_low_cycles_2frames", 32'(vs_low_cnt), 32'd64);
    chk("fs_pulses_2frames", 32'(fs_cnt), 32'd2);
    chk("fc_after_2frames", 32'(sfc), 32'd2);

    run("to_midframe", 16 * 3 + 11);  // ends on (11,3), inside hsync
    chk("small_pre_reset_hs", 32'(shs), 32'd0);
    async_reset("midframe_reset");
    run("reset_hold_small", 2);

    release_reset();
    clear_counts();
    run("frames_255", 255 * 176);
    chk("fc_at_255", 32'(sfc), 32'd255);
    run("frame_256", 176);
    chk("fs_pulses_256", 32'(fs_cnt), 32'd256);
    chk("fc_wrap_to_0", 32'(sfc), 32'd0);
    chk("fs_on_wrap", 32'(sfs), 32'd1);
    run("after_wrap", 1);
    chk("fs_single_cycle", 32'(sfs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have port vga_clk, input, 1: pixel clock (25 MHz nominal), all state on posedge.
REQ-002 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-003 SHALL have port DrawX, output, 10: horizontal pixel counter, range 0..799.
REQ-004 SHALL have port DrawY, output, 10: vertical line counter, range 0..524.
REQ-005 SHALL have port hs, output, 1: horizontal sync, active-low.
REQ-006 SHALL have port vs, output, 1: vertical sync, active-low.
REQ-007 SHALL have port blank, output, 1: display enable; 1 = active video (DrawX<640 and DrawY<480), 0 = blanking.
REQ-008 SHALL have port frame_start, output, 1: one-cycle pulse marking pixel (0,0).
REQ-009 SHALL have port frame_count, output, 8: completed-frame counter for sprite animation.

Function
REQ-010 SHALL use fixed 640x480@60 timing: H active 640, front porch 16, sync 96, back porch 48, total 800; V active 480, front porch 10, sync 2, back porch 33, total 525.
REQ-011 SHALL increment DrawX by 1 every vga_clk cycle; at DrawX=799 it wraps to 0 on the next edge.
REQ-012 SHALL increment DrawY only on the cycle DrawX wraps 799->0; at DrawY=524 together with DrawX=799, both wrap to 0.
REQ-013 SHALL implement hs, vs, blank and frame_start as registers computed from next-counter values, so each is cycle-aligned with the DrawX/DrawY it describes (zero skew, no combinational output paths).
REQ-014 SHALL drive hs=0 exactly when DrawX is in 656..751, else 1.
REQ-015 SHALL drive vs=0 exactly when DrawY is in 490..491, for all DrawX on those lines, else 1.
REQ-016 SHALL drive blank=1 exactly when DrawX<640 and DrawY<480, except for the post-reset case in REQ-020.
REQ-017 SHALL drive frame_start=1 exactly in the cycle where DrawX=0 and DrawY=0 after a wrap from (799,524); it SHALL NOT pulse on the first cycle after reset release.
REQ-018 SHALL increment frame_count, modulo 256, on the same edge that raises frame_start; 255 wraps to 0 with no flag.
REQ-019 SHALL never produce counter values outside their ranges; compare values are package constants, and counter arithmetic is 10-bit with explicit wrap, with no reliance on overflow.

Reset
REQ-020 SHALL, while reset_n=0, hold DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0 and frame_count=0; pixel (0,0) of the first frame is therefore dark.
REQ-021 SHALL resume counting on the first posedge after reset_n rises: DrawX becomes 1 and blank becomes 1, and timing is then fully per REQ-011..018.
REQ-022 SHALL, on reset asserted mid-frame, clear all state immediately (asynchronously) with no partial sync pulse extended, and restart from REQ-020.

Structure
REQ-023 SHALL take timing constants from shared package vga_pkg: H_ACTIVE, H_FP, H_SYNC, H_BP, H_TOTAL, V_ACTIVE, V_FP, V_SYNC, V_BP, V_TOTAL, and the derived sync start/end values; sprite and ROM-address stages use the same package.
REQ-024 SHALL be a single module with no sub-modules; the counter and output registers are a small pipeline of next-state logic feeding registers.

Verification
REQ-025 SHALL cover the horizontal line: from reset release, observe one line -> blank=1 for DrawX 0..639, hs=0 for DrawX 656..751 (96 cycles), DrawX 799->0 with DrawY 0->1.
REQ-026 SHALL cover the vertical frame: run 525x800 cycles -> vs=0 only on DrawY 490..491 (1600 cycles), blank=0 for all of DrawY 480..524.
REQ-027 SHALL cover frame wrap: at (799,524) -> next cycle (0,0), frame_start=1 for exactly 1 cycle, frame_count 0->1; no frame_start on the first post-reset cycle.
REQ-028 SHALL cover mid-frame reset: reset_n=0 at DrawX=700, DrawY=300, during hs low -> immediately hs=1, blank=0, counters 0, frame_count 0; after release, the line timing repeats REQ-025.
REQ-029 SHALL cover frame_count wrap: run 256 frames -> frame_count 255->0 on the 256th frame_start.
REQ-030 SHALL cover alignment via a scoreboard: every cycle, compare hs/vs/blank against a reference model of DrawX/DrawY -> zero mismatches over 2 full frames.
